// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between the execute stage (port 0) and the
// address/branch-compare unit (port 1). Requests are granted round-robin. The
// operands are held on the ALU for LAT cycles. The result is then held on the
// winner's response channel until that requester accepts it.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0 (execute stage)
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  // requester 1 (address/branch-compare unit)
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  // shared ALU
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  // response channels
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  input  logic             rsp1_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // The counter is 3 bits wide because LAT is limited to 1..7.
  localparam logic [2:0] LAT_CNT = 3'(LAT);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             gnt_q, gnt_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rerr_q, rerr_d;

  logic             take;
  logic             sel;
  logic [2:0]       sel_ctrl;

  // Arbitration: the prio requester wins a tie, and a lone requester always wins.
  always_comb begin
    take     = req0_valid | req1_valid;
    sel      = (req0_valid && req1_valid) ? prio_q : req1_valid;
    sel_ctrl = sel ? req1_ctrl : req0_ctrl;
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    gnt_d      = gnt_q;
    ctrl_d     = ctrl_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rerr_d     = rerr_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req0_ready = take & ~sel;
        req1_ready = take & sel;
        if (take) begin
          gnt_d  = sel;
          prio_d = ~sel;
          ctrl_d = sel_ctrl;
          a_d    = sel ? req1_a : req0_a;
          b_d    = sel ? req1_b : req0_b;
          if (sel_ctrl == 3'd0) begin
            // Illegal code: the ALU is not used and the error is reported directly.
            rdata_d = '0;
            rerr_d  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = LAT_CNT;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = alu_result;
          rerr_d  = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (gnt_q ? rsp1_ready : rsp0_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // The ALU sees the operands only during EXEC. The response is shown only on the winner's channel.
  always_comb begin
    alu_ctrl   = (state_q == EXEC) ? ctrl_q : 3'd0;
    alu_a      = (state_q == EXEC) ? a_q : '0;
    alu_b      = (state_q == EXEC) ? b_q : '0;
    rsp0_valid = (state_q == RESP) && !gnt_q;
    rsp1_valid = (state_q == RESP) && gnt_q;
    rsp0_data  = rsp0_valid ? rdata_q : '0;
    rsp1_data  = rsp1_valid ? rdata_q : '0;
    rsp0_err   = rsp0_valid & rerr_q;
    rsp1_err   = rsp1_valid & rerr_q;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single CPU ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch-compare unit.
- Each requester issues an operation over a valid/ready handshake. The arbiter grants round-robin, drives the ALU operands and control, and waits the fixed ALU latency. It then holds the result on the winner's response channel until that requester accepts it.
- Sits between the decode-side ALU control (3-bit AluCtrl codes) and the ALU datapath.

Parameters:
- WIDTH, 32, operand/result width in bits
- LAT, 1, ALU latency in cycles from operand drive to valid result (1..7)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_ctrl  input  3  ALU control code (1..7 valid, 0 illegal)
- req0_a, req0_b  input  WIDTH  operands
- req1_valid, req1_ready, req1_ctrl, req1_a, req1_b  as above, for requester 1
- alu_ctrl  output  3  control to ALU
- alu_a, alu_b  output  WIDTH  operands to ALU
- alu_result  input  WIDTH  ALU result, valid LAT cycles after operands are driven
- rsp0_valid  output  1  result available for requester 0
- rsp0_data  output  WIDTH  result
- rsp0_err  output  1  operation had illegal ctrl
- rsp0_ready  input  1  requester 0 accepts response
- rsp1_valid, rsp1_data, rsp1_err, rsp1_ready  as above, for requester 1

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE and prio = 0 (requester 0 favoured).
  - All outputs are 0: alu_ctrl, alu_a, alu_b, rsp*_valid, rsp*_data, rsp*_err.
  - Counter is 0 and the grant register is cleared.
  - Reset mid-operation abandons the operation with no response.
- States: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready = 1 combinationally for exactly one requester N, and only in IDLE.
  - N is the only valid requester, or prio when both are valid.
  - On handshake (valid & ready), the arbiter latches gnt = N and the ctrl/operands into registers.
  - prio becomes the other requester (round-robin, toggles only on an accepted request).
  - ctrl != 0: go to EXEC with cnt = LAT.
  - ctrl == 0: skip the ALU; load rsp data = 0 and err = 1, and go to RESP next cycle.
- EXEC:
  - alu_ctrl, alu_a, alu_b are driven from registers for the whole state. They are 0 in all other states.
  - cnt decrements each cycle.
  - When cnt reaches 1, capture alu_result into the response register with err = 0 and go to RESP.
  - An accepted request therefore has its result visible LAT+1 cycles after the handshake edge.
- RESP:
  - rsp{gnt}_valid = 1 with data and err stable until rsp{gnt}_ready is sampled high. The other response channel stays 0.
  - On acceptance, valid drops next cycle and the state returns to IDLE.
  - The next request can be accepted in the first IDLE cycle. Back-to-back throughput is one op per LAT+2 cycles.
- Input stability and ordering:
  - reqN_ready is 0 outside IDLE.
  - Requester inputs are ignored except at the handshake; operands may change after acceptance.
  - A requester may deassert valid before ready is given.
  - A request arriving while the arbiter is busy waits; no request is lost, reordered, or duplicated.
- Simultaneous events:
  - Both valid in IDLE: prio wins.
  - Only one valid: it wins regardless of prio, and prio still toggles to the other requester.
- rsp*_ready asserted while the matching rsp*_valid = 0 has no effect.
- Results are returned unmodified; the arbiter performs no width change.

Test Plan:
- Reset, then req0 with ctrl=ADD(1), a=5, b=7, LAT=1 → req0_ready=1 at cycle 0; alu_ctrl=1, alu_a=5, alu_b=7 during EXEC; rsp0_valid=1, rsp0_data=12, rsp0_err=0 at cycle 2; rsp1_valid stays 0.
- Both requesters valid every cycle with responses always accepted → grants alternate 0,1,0,1. Each op completes in LAT+2 cycles; 8 ops give 4 per requester.
- req1 with ctrl=0 → ALU outputs stay 0; rsp1_valid=1, rsp1_data=0, rsp1_err=1 one cycle after the handshake.
- Response backpressure: rsp0_ready held low for 5 cycles while req1 is valid → rsp0 stays stable, req1_ready=0 throughout; req1 is accepted the cycle after rsp0 is accepted.
- LAT=3, SUB with a=10, b=3 → alu_* held for 3 cycles; rsp data=7 appears 4 cycles after the handshake.
- rst_n pulsed low during EXEC → all outputs go to 0 immediately; after release, prio=0, and a new req0 is accepted and completes correctly.
